// File: rtl/mmio_fifo_port_pkg.sv
// Shared definitions for the mmio_fifo_port window: register offsets, STATUS/CTRL
// bit positions and the default window base address.
package mmio_fifo_port_pkg;

    localparam logic [6:0] DEF_BASE_ADDR = 7'h7C;

    typedef enum logic [1:0] {
        OFS_TXDATA = 2'd0,
        OFS_RXDATA = 2'd1,
        OFS_STATUS = 2'd2,
        OFS_CTRL   = 2'd3
    } reg_ofs_e;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_TX_OVF   = 4;
    localparam int ST_RX_UNF   = 5;
    localparam int ST_TX_CNT   = 8;
    localparam int ST_RX_CNT   = 16;

    localparam int CT_FLUSH_TX  = 0;
    localparam int CT_FLUSH_RX  = 1;
    localparam int CT_CLR_STICK = 2;
    localparam int CT_IRQ_MASK  = 3;

endpackage

// File: rtl/mmio_fifo_port_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output; flush overrides push/pop.
// Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: storage is deliberately left out of reset; only pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_fifo_port.sv
// Memory-mapped TX/RX FIFO port on the CPU bus, 4-word window at BASE_ADDR.
// Define MMIO_FIFO_IRQ_EN to enable the registered interrupt output; otherwise IRQ is tied 0.
module mmio_fifo_port
    import mmio_fifo_port_pkg::*;
#(
    parameter logic [6:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int         DEPTH_LOG2 = 3,
    parameter int         WIDTH      = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CS,
    input  logic              WE,
    input  logic [6:0]        ADDR,
    inout  wire  [WIDTH-1:0]  Mem_Bus,
    output logic              SEL,
    output logic [WIDTH-1:0]  TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY,
    input  logic [WIDTH-1:0]  RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    output logic              IRQ
);

    localparam int CW = DEPTH_LOG2 + 1;

    reg_ofs_e          ofs;
    reg_ofs_e          acc_ofs;
    logic              acc;
    logic              same_acc;
    logic              acc_first;
    logic              acc_end;
    logic              in_access;
    logic [6:0]        acc_addr;
    logic              acc_we;
    logic              rd_was_empty;
    logic              tx_wr;
    logic              ctrl_wr;
    logic              ld_rx_end;
    logic              rx_pop;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0]     tx_count, rx_count;
    logic [WIDTH-1:0]  rx_dout;
    logic [WIDTH-1:0]  status;
    logic [WIDTH-1:0]  rdata;
    logic              tx_ovf, rx_unf, irq_mask;

    assign SEL       = (ADDR[6:2] == BASE_ADDR[6:2]);
    assign acc       = SEL && CS;
    assign ofs       = reg_ofs_e'(ADDR[1:0]);
    assign acc_ofs   = reg_ofs_e'(acc_addr[1:0]);

    // An access is a run of selected cycles with ADDR/WE unchanged; a change starts a new one.
    assign same_acc  = in_access && (ADDR == acc_addr) && (WE == acc_we);
    assign acc_first = acc && !same_acc;
    assign acc_end   = in_access && !(acc && same_acc);

    assign tx_wr     = acc_first && WE && (ofs == OFS_TXDATA);
    assign ctrl_wr   = acc_first && WE && (ofs == OFS_CTRL);
    assign ld_rx_end = acc_end && !acc_we && (acc_ofs == OFS_RXDATA);
    assign rx_pop    = ld_rx_end && !rd_was_empty;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (tx_wr),
        .pop   (TX_READY && !tx_empty),
        .flush (ctrl_wr && Mem_Bus[CT_FLUSH_TX]),
        .din   (Mem_Bus),
        .dout  (TX_DATA),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (RX_VALID),
        .pop   (rx_pop),
        .flush (ctrl_wr && Mem_Bus[CT_FLUSH_RX]),
        .din   (RX_DATA),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    assign TX_VALID = !tx_empty;
    assign RX_READY = !rx_full;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            in_access    <= 1'b0;
            acc_addr     <= '0;
            acc_we       <= 1'b0;
            rd_was_empty <= 1'b0;
        end else begin
            in_access <= acc;
            acc_addr  <= ADDR;
            acc_we    <= WE;
            if (acc_first)
                rd_was_empty <= rx_empty;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_ovf   <= 1'b0;
            rx_unf   <= 1'b0;
            irq_mask <= 1'b0;
        end else begin
            if (tx_wr && tx_full)
                tx_ovf <= 1'b1;
            if (ld_rx_end && rd_was_empty)
                rx_unf <= 1'b1;
            // NOTE: the later non-blocking assignment wins, so a clear issued by the
            // access that starts as an RX underflow access ends takes priority.
            if (ctrl_wr) begin
                if (Mem_Bus[CT_CLR_STICK]) begin
                    tx_ovf <= 1'b0;
                    rx_unf <= 1'b0;
                end
                irq_mask <= Mem_Bus[CT_IRQ_MASK];
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        status                  = '0;
        status[ST_TX_FULL]      = tx_full;
        status[ST_TX_EMPTY]     = tx_empty;
        status[ST_RX_FULL]      = rx_full;
        status[ST_RX_EMPTY]     = rx_empty;
        status[ST_TX_OVF]       = tx_ovf;
        status[ST_RX_UNF]       = rx_unf;
        status[ST_TX_CNT +: CW] = tx_count;
        status[ST_RX_CNT +: CW] = rx_count;
    end

    always_comb begin
        rdata = '0;
        case (ofs)
            OFS_RXDATA: rdata = rx_empty ? '0 : rx_dout;
            OFS_STATUS: rdata = status;
            OFS_CTRL:   rdata[CT_IRQ_MASK] = irq_mask;
            default:    rdata = '0;
        endcase
    end

    assign Mem_Bus = (acc && !WE) ? rdata : 'z;

`ifdef MMIO_FIFO_IRQ_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            IRQ <= 1'b0;
        else
            IRQ <= irq_mask && (!rx_empty || tx_ovf || rx_unf);
    end
`else
    assign IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_fifo_port.sv
// Self-checking bench for mmio_fifo_port: queue-based model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mmio_fifo_port;

    localparam logic [31:0] IDLE_PAT = 32'hA5A5_5A5A;

    logic        CLK;
    logic        RST_N;
    logic        CS;
    logic        WE;
    logic [6:0]  ADDR;
    wire  [31:0] Mem_Bus;
    logic        SEL;
    logic [31:0] TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic [31:0] RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic        IRQ;

    logic [31:0] bus_wdata;
    int          n_cmp;
    int          n_err;
    bit          done;

    // Bench drives the bus whenever the CPU is not reading.
    assign Mem_Bus = (CS && !WE) ? 'z : bus_wdata;

    mmio_fifo_port dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CS       (CS),
        .WE       (WE),
        .ADDR     (ADDR),
        .Mem_Bus  (Mem_Bus),
        .SEL      (SEL),
        .TX_DATA  (TX_DATA),
        .TX_VALID (TX_VALID),
        .TX_READY (TX_READY),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_READY (RX_READY),
        .IRQ      (IRQ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (actual running, required finished)");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%08h required=%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_tx[$];
    logic [31:0] m_rx[$];
    bit          m_ovf, m_unf, m_mask, m_irq;
    bit          m_in, m_we, m_rd_empty;
    logic [6:0]  m_addr;

    function automatic logic [31:0] mdl_status();
        logic [31:0] s;
        s        = '0;
        s[0]     = (m_tx.size() == 8);
        s[1]     = (m_tx.size() == 0);
        s[2]     = (m_rx.size() == 8);
        s[3]     = (m_rx.size() == 0);
        s[4]     = m_ovf;
        s[5]     = m_unf;
        s[11:8]  = 4'(m_tx.size());
        s[19:16] = 4'(m_rx.size());
        return s;
    endfunction

    function automatic logic [31:0] mdl_rdata(input logic [1:0] o);
        case (o)
            2'd1:    return (m_rx.size() != 0) ? m_rx[0] : 32'h0;
            2'd2:    return mdl_status();
            2'd3:    return {28'h0, m_mask, 3'b000};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        bit acc, same, first, last, irq_next, tx_pop, tx_push, rx_push, rx_pop, unf_set;
        if (!RST_N) begin
            m_tx.delete();
            m_rx.delete();
            m_ovf = 0; m_unf = 0; m_mask = 0; m_irq = 0;
            m_in = 0; m_we = 0; m_rd_empty = 0; m_addr = '0;
        end else begin
            acc      = CS && (ADDR[6:2] == 5'h1F);
            same     = m_in && (ADDR == m_addr) && (WE == m_we);
            first    = acc && !same;
            last     = m_in && !(acc && same);
            irq_next = m_mask && ((m_rx.size() != 0) || m_ovf || m_unf);
            tx_pop   = TX_READY && (m_tx.size() != 0);
            tx_push  = 0;
            if (first && WE && ADDR[1:0] == 2'd0) begin
                if (m_tx.size() == 8) m_ovf = 1;
                else tx_push = 1;
            end
            rx_push  = RX_VALID && (m_rx.size() < 8);
            rx_pop   = last && !m_we && (m_addr[1:0] == 2'd1) && !m_rd_empty;
            unf_set  = last && !m_we && (m_addr[1:0] == 2'd1) && m_rd_empty;
            if (first && !WE && ADDR[1:0] == 2'd1) m_rd_empty = (m_rx.size() == 0);
            if (tx_pop)  void'(m_tx.pop_front());
            if (tx_push) m_tx.push_back(Mem_Bus);
            if (rx_pop)  void'(m_rx.pop_front());
            if (rx_push) m_rx.push_back(RX_DATA);
            if (unf_set) m_unf = 1;
            if (first && WE && ADDR[1:0] == 2'd3) begin
                if (Mem_Bus[0]) m_tx.delete();
                if (Mem_Bus[1]) m_rx.delete();
                if (Mem_Bus[2]) begin m_ovf = 0; m_unf = 0; end
                m_mask = Mem_Bus[3];
            end
`ifdef MMIO_FIFO_IRQ_EN
            m_irq = irq_next;
`else
            m_irq = 0;
`endif
            m_in = acc; m_addr = ADDR; m_we = WE;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge CLK) begin
        if (!done) begin
            check("tx_valid", 32'(TX_VALID), 32'(m_tx.size() != 0));
            if (m_tx.size() != 0) check("tx_data", TX_DATA, m_tx[0]);
            check("rx_ready", 32'(RX_READY), 32'(m_rx.size() < 8));
            check("irq", 32'(IRQ), 32'(m_irq));
            check("sel", 32'(SEL), 32'(ADDR[6:2] == 5'h1F));
            if (CS && !WE) check("rdata", Mem_Bus, mdl_rdata(ADDR[1:0]));
            else           check("bus_free", Mem_Bus, bus_wdata);
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic bus_write(input logic [6:0] a, input logic [31:0] d);
        @(posedge CLK); #1;
        CS = 1; WE = 1; ADDR = a; bus_wdata = d;
        @(posedge CLK); #1;
        CS = 0; WE = 0; bus_wdata = IDLE_PAT;
    endtask

    task automatic bus_read(input logic [6:0] a, input int ncyc, output logic [31:0] d);
        @(posedge CLK); #1;
        CS = 1; WE = 0; ADDR = a;
        @(negedge CLK);
        d = Mem_Bus;
        repeat (ncyc) @(posedge CLK);
        #1;
        CS = 0;
    endtask

    task automatic stream_rx(input logic [31:0] d);
        @(posedge CLK); #1;
        RX_VALID = 1; RX_DATA = d;
    endtask

    task automatic stream_rx_stop();
        @(posedge CLK); #1;
        RX_VALID = 0;
    endtask

    logic [31:0] rd;

    initial begin
        n_cmp = 0; n_err = 0; done = 0;
        RST_N = 0; CS = 0; WE = 0; ADDR = 7'h00; bus_wdata = IDLE_PAT;
        TX_READY = 0; RX_DATA = '0; RX_VALID = 0;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1;

        // 1: reset in the middle of an RXDATA load clears everything, no pop committed.
        bus_write(7'h7C, 32'h0000_0055);
        stream_rx(32'hDEAD_0001);
        stream_rx_stop();
        @(posedge CLK); #1;
        CS = 1; WE = 0; ADDR = 7'h7D;
        @(negedge CLK);
        check("t1_rx_head", Mem_Bus, 32'hDEAD_0001);
        @(posedge CLK); #1;
        RST_N = 0;
        @(negedge CLK);
        check("t1_rst_txvalid", 32'(TX_VALID), 32'h0);
        check("t1_rst_rxready", 32'(RX_READY), 32'h1);
        @(posedge CLK); #1;
        CS = 0;
        @(posedge CLK); #1;
        RST_N = 1;
        @(negedge CLK);
        check("t1_bus_idle", Mem_Bus, IDLE_PAT);
        bus_read(7'h7E, 1, rd);
        check("t1_status", rd, 32'h0000_000A);

        // 2: two stores held, out-of-window store ignored, then drained in order.
        bus_write(7'h7C, 32'h0000_0011);
        bus_write(7'h7C, 32'h0000_0022);
        bus_write(7'h7B, 32'h0000_0099);
        bus_read(7'h7E, 1, rd);
        check("t2_status", rd, 32'h0000_0208);
        @(posedge CLK); #1;
        TX_READY = 1;
        @(negedge CLK);
        check("t2_first", TX_DATA, 32'h0000_0011);
        @(negedge CLK);
        check("t2_second", TX_DATA, 32'h0000_0022);
        @(negedge CLK);
        check("t2_drained", 32'(TX_VALID), 32'h0);
        @(posedge CLK); #1;
        TX_READY = 0;

        // 3: three streamed words, 2-cycle load pops exactly once.
        stream_rx(32'h0000_00A1);
        stream_rx(32'h0000_00B2);
        stream_rx(32'h0000_00C3);
        stream_rx_stop();
        bus_read(7'h7E, 1, rd);
        check("t3_status3", rd, 32'h0003_0002);
        bus_read(7'h7D, 2, rd);
        check("t3_lw", rd, 32'h0000_00A1);
        bus_read(7'h7E, 1, rd);
        check("t3_status2", rd, 32'h0002_0002);
        bus_read(7'h7D, 1, rd);
        check("t3_lw2", rd, 32'h0000_00B2);
        bus_read(7'h7D, 1, rd);
        check("t3_lw3", rd, 32'h0000_00C3);
        bus_read(7'h7E, 1, rd);
        check("t3_status0", rd, 32'h0000_000A);

        // 4: nine stores into an 8-deep FIFO, the ninth is dropped.
        for (int i = 1; i <= 9; i++) bus_write(7'h7C, 32'h100 + 32'(i));
        bus_read(7'h7E, 1, rd);
        check("t4_status", rd, 32'h0000_0819);
        @(posedge CLK); #1;
        TX_READY = 1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK);
            check("t4_drain", TX_DATA, 32'h100 + 32'(i));
        end
        @(negedge CLK);
        check("t4_no_ninth", 32'(TX_VALID), 32'h0);
        @(posedge CLK); #1;
        TX_READY = 0;
        bus_write(7'h7F, 32'h0000_0004);

        // 5: load from empty RX returns 0 and sets rx_unf; CTRL clear removes it.
        bus_read(7'h7D, 1, rd);
        check("t5_empty_lw", rd, 32'h0000_0000);
        bus_read(7'h7E, 1, rd);
        check("t5_unf", rd, 32'h0000_002A);
        bus_write(7'h7F, 32'h0000_0004);
        bus_read(7'h7E, 1, rd);
        check("t5_cleared", rd, 32'h0000_000A);

        // 6: flush TX in the same cycle the stream pops.
        bus_write(7'h7C, 32'h0000_0077);
        bus_write(7'h7C, 32'h0000_0088);
        @(posedge CLK); #1;
        CS = 1; WE = 1; ADDR = 7'h7F; bus_wdata = 32'h0000_0001; TX_READY = 1;
        @(posedge CLK); #1;
        CS = 0; WE = 0; bus_wdata = IDLE_PAT; TX_READY = 0;
        @(negedge CLK);
        check("t6_txvalid", 32'(TX_VALID), 32'h0);
        bus_read(7'h7E, 1, rd);
        check("t6_status", rd, 32'h0000_000A);

        // IRQ: mask set, one RX word arrives, IRQ follows one cycle later.
        bus_write(7'h7F, 32'h0000_0008);
        bus_read(7'h7F, 1, rd);
        check("irq_ctrl_rd", rd, 32'h0000_0008);
        stream_rx(32'h0000_00AB);
        @(negedge CLK);
        check("irq_before", 32'(IRQ), 32'h0);
        stream_rx_stop();
        @(negedge CLK);
        check("irq_same_cycle", 32'(IRQ), 32'h0);
        @(negedge CLK);
`ifdef MMIO_FIFO_IRQ_EN
        check("irq_next_cycle", 32'(IRQ), 32'h1);
`else
        check("irq_tied_low", 32'(IRQ), 32'h0);
`endif
        bus_write(7'h7F, 32'h0000_0002);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("irq_after_flush", 32'(IRQ), 32'h0);
        bus_read(7'h7E, 1, rd);
        check("end_status", rd, 32'h0000_000A);

        repeat (2) @(posedge CLK);
        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
